// File: rtl/rv16_operand_fetch.sv
// Decode/operand-fetch stage: regfile address decode, 1-deep output register, busy scoreboard.
// Optional same-cycle writeback bypass is enabled by defining RV16_OF_FORWARD_EN.
module rv16_operand_fetch #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [XLEN-1:0]   i_instr,
   input  logic [XLEN-1:0]   i_pc,
   output logic [REG_AW-1:0] o_rs1_addr,
   output logic [REG_AW-1:0] o_rs2_addr,
   input  logic [XLEN-1:0]   i_rs1_data,
   input  logic [XLEN-1:0]   i_rs2_data,
   input  logic              i_wb_write_enable,
   input  logic [REG_AW-1:0] i_wb_rd_addr,
   input  logic [XLEN-1:0]   i_wb_rd_data,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [XLEN-1:0]   o_pc,
   output logic [XLEN-1:0]   o_instr,
   output logic [XLEN-1:0]   o_rs1_val,
   output logic [XLEN-1:0]   o_rs2_val,
   output logic [REG_AW-1:0] o_rd_addr
);
   localparam int unsigned NREG      = 1 << REG_AW;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_n;
   logic [NREG-1:0]   clr;
   logic [NREG-1:0]   busy_eff;
   logic [NREG-1:0]   src_busy;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic [REG_AW-1:0] rd;
   logic [6:0]        opcode;
   logic              writes_rd;
   logic              hazard;
   logic              accept;
   logic              valid_n;
   logic [XLEN-1:0]   rs1_val;
   logic [XLEN-1:0]   rs2_val;

   assign opcode     = i_instr[6:0];
   assign rd         = i_instr[7 +: REG_AW];
   assign rs1        = i_instr[15 +: REG_AW];
   assign rs2        = i_instr[20 +: REG_AW];
   assign o_rs1_addr = rs1;
   assign o_rs2_addr = rs2;
   assign writes_rd  = (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != '0);

   // Writeback clear vector; x0 is never cleared because it is never set.
   always_comb begin
      clr = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         clr[r] = i_wb_write_enable && (i_wb_rd_addr == REG_AW'(r));
      end
   end

   assign busy_eff = busy & ~clr;

`ifdef RV16_OF_FORWARD_EN
   assign src_busy = busy_eff;
   assign rs1_val  = (rs1 == '0) ? '0 : (clr[rs1] ? i_wb_rd_data : i_rs1_data);
   assign rs2_val  = (rs2 == '0) ? '0 : (clr[rs2] ? i_wb_rd_data : i_rs2_data);
`else
   logic unused_wb_data;
   assign unused_wb_data = ^i_wb_rd_data;
   assign src_busy = busy;
   assign rs1_val  = (rs1 == '0) ? '0 : i_rs1_data;
   assign rs2_val  = (rs2 == '0) ? '0 : i_rs2_data;
`endif

   assign hazard  = ((rs1 != '0) && src_busy[rs1]) ||
                    ((rs2 != '0) && src_busy[rs2]) ||
                    (writes_rd && busy_eff[rd]);
   assign o_ready = (!o_valid || i_ready) && !hazard && !i_flush;
   assign accept  = i_valid && o_ready;

   // Next valid / scoreboard; a flushed instruction still held here releases its rd.
   always_comb begin
      busy_n  = busy_eff;
      valid_n = o_valid;
      if (i_flush) begin
         valid_n = 1'b0;
         if (o_valid && !i_ready) begin
            busy_n[o_rd_addr] = 1'b0;
         end
      end else if (accept) begin
         valid_n = 1'b1;
         if (writes_rd) begin
            busy_n[rd] = 1'b1;
         end
      end else if (o_valid && i_ready) begin
         valid_n = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= '0;
         o_valid   <= 1'b0;
         o_pc      <= '0;
         o_instr   <= '0;
         o_rs1_val <= '0;
         o_rs2_val <= '0;
         o_rd_addr <= '0;
      end else begin
         busy    <= busy_n;
         o_valid <= valid_n;
         if (accept) begin
            o_pc      <= i_pc;
            o_instr   <= i_instr;
            o_rs1_val <= rs1_val;
            o_rs2_val <= rs2_val;
            o_rd_addr <= writes_rd ? rd : '0;
         end
      end
   end
endmodule

// File: tb/tb_rv16_operand_fetch.sv
// Self-checking bench for rv16_operand_fetch; honours RV16_OF_FORWARD_EN like the design.
`timescale 1ns/1ps
module tb_rv16_operand_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, ex_ready, wb_we, flush;
   logic [31:0] in_instr, in_pc, wb_data;
   logic [4:0]  wb_addr;
   logic        o_ready, o_valid;
   logic [4:0]  rs1_addr, rs2_addr, o_rd_addr;
   logic [31:0] rs1_data, rs2_data, o_pc, o_instr, o_rs1_val, o_rs2_val;

   logic [31:0] rf [32];
   bit          m_busy [32];
   logic        m_valid;
   logic [31:0] m_pc, m_instr, m_rs1, m_rs2;
   logic [4:0]  m_rd;
   int          n_pass = 0;
   int          n_total = 0;
`ifdef RV16_OF_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   always #5 clk = ~clk;

   assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];

   rv16_operand_fetch dut (
      .clk(clk), .rst_n(rst_n), .i_valid(in_valid), .o_ready(o_ready),
      .i_instr(in_instr), .i_pc(in_pc), .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
      .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_wb_write_enable(wb_we),
      .i_wb_rd_addr(wb_addr), .i_wb_rd_data(wb_data), .i_flush(flush), .o_valid(o_valid),
      .i_ready(ex_ready), .o_pc(o_pc), .o_instr(o_instr), .o_rs1_val(o_rs1_val),
      .o_rs2_val(o_rs2_val), .o_rd_addr(o_rd_addr)
   );

   function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'h13};
   endfunction
   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction

   // Reference rules computed from the current driven inputs and model state.
   function automatic bit f_writes(input logic [31:0] ins);
      return (ins[6:0] != 7'h23) && (ins[6:0] != 7'h63) && (ins[11:7] != 5'd0);
   endfunction
   function automatic bit f_clr(input int r);
      return wb_we && (int'(wb_addr) == r) && (r != 0);
   endfunction
   function automatic bit f_src_busy(input int r);
      if (r == 0) return 1'b0;
      return FWD ? (m_busy[r] && !f_clr(r)) : m_busy[r];
   endfunction
   function automatic bit f_ready();
      int  s1 = int'(in_instr[19:15]);
      int  s2 = int'(in_instr[24:20]);
      int  d  = int'(in_instr[11:7]);
      bit  haz;
      haz = f_src_busy(s1) || f_src_busy(s2) || (f_writes(in_instr) && m_busy[d] && !f_clr(d));
      return (!m_valid || ex_ready) && !haz && !flush;
   endfunction
   function automatic logic [31:0] f_operand(input int r);
      if (r == 0) return 32'd0;
      if (FWD && f_clr(r)) return wb_data;
      return rf[r];
   endfunction
   function automatic logic [31:0] f_busy_vec();
      logic [31:0] v;
      for (int r = 0; r < 32; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] p, input bit rdy);
      in_valid = v; in_instr = ins; in_pc = p; ex_ready = rdy;
      wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; flush = 1'b0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_valid = 1'b0; m_pc = '0; m_instr = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
   endtask

   // Advance one clock: model next state computed before the edge, committed #1 after it.
   task automatic tick();
      bit          acc;
      bit          nb [32];
      logic        nv;
      logic [31:0] npc, nins, n1, n2;
      logic [4:0]  nrd;
      acc = in_valid && f_ready();
      nb = m_busy;
      for (int r = 0; r < 32; r++) if (f_clr(r)) nb[r] = 1'b0;
      nv = m_valid; npc = m_pc; nins = m_instr; n1 = m_rs1; n2 = m_rs2; nrd = m_rd;
      if (flush) begin
         nv = 1'b0;
         if (m_valid && !ex_ready) nb[m_rd] = 1'b0;
      end else if (acc) begin
         nv = 1'b1; npc = in_pc; nins = in_instr;
         n1 = f_operand(int'(in_instr[19:15]));
         n2 = f_operand(int'(in_instr[24:20]));
         nrd = f_writes(in_instr) ? in_instr[11:7] : 5'd0;
         if (nrd != 5'd0) nb[nrd] = 1'b1;
      end else if (m_valid && ex_ready) begin
         nv = 1'b0;
      end
      @(posedge clk);
      #1;
      if (wb_we && wb_addr != 5'd0) rf[wb_addr] = wb_data;
      m_busy = nb; m_valid = nv; m_pc = npc; m_instr = nins; m_rs1 = n1; m_rs2 = n2; m_rd = nrd;
   endtask

   task automatic test_reset();
      for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : $urandom;
      model_reset();
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if ({o_valid, o_pc, o_instr, o_rs1_val, o_rs2_val, o_rd_addr} !== 134'd0)
         $display("FAIL reset_outputs: got v=%b pc=%h rd=%0d want all zero", o_valid, o_pc, o_rd_addr); else n_pass++;
      n_total++; if (dut.busy !== 32'd0) $display("FAIL reset_busy: got %h want 0", dut.busy); else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_passthrough();
      rf[1] = 32'h1234;
      drive(1'b1, enc_i(5'd5, 5'd1, 12'd7), 32'h100, 1'b1);
      #1;
      n_total++; if (o_ready !== 1'b1) $display("FAIL pass_ready: got %b want 1", o_ready); else n_pass++;
      n_total++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd7}) $display("FAIL pass_addr: got %0d/%0d want 1/7", rs1_addr, rs2_addr); else n_pass++;
      tick();
      n_total++; if ({o_valid, o_pc, o_rs1_val, o_rd_addr} !== {1'b1, 32'h100, 32'h1234, 5'd5})
         $display("FAIL pass_out: got v=%b pc=%h rs1=%h rd=%0d want 1/100/1234/5", o_valid, o_pc, o_rs1_val, o_rd_addr); else n_pass++;
      n_total++; if (dut.busy[5] !== 1'b1) $display("FAIL pass_busy5: got %b want 1", dut.busy[5]); else n_pass++;
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
      n_total++; if (o_valid !== 1'b0) $display("FAIL pass_drain: got %b want 0", o_valid); else n_pass++;
   endtask

   task automatic test_raw();
      int   acc_c = -1;
      logic got;
      drive(1'b1, enc_r(5'd6, 5'd5, 5'd0), 32'h104, 1'b1);
      for (int c = 0; c < 6; c++) begin
         wb_we = (c == 2); wb_addr = 5'd5; wb_data = 32'hBEEF;
         #1;
         n_total++; if (o_ready !== f_ready()) $display("FAIL raw_ready c%0d: got %b want %b", c, o_ready, f_ready()); else n_pass++;
         got = o_ready;
         tick();
         if (got === 1'b1) begin acc_c = c; break; end
      end
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      n_total++; if (acc_c != (FWD ? 2 : 3)) $display("FAIL raw_accept_cycle: got %0d want %0d", acc_c, FWD ? 2 : 3); else n_pass++;
      n_total++; if ({o_valid, o_rs1_val, o_rd_addr} !== {1'b1, 32'hBEEF, 5'd6})
         $display("FAIL raw_out: got v=%b rs1=%h rd=%0d want 1/beef/6", o_valid, o_rs1_val, o_rd_addr); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins0, ins1;
      ins0 = enc_i(5'd8, 5'd0, 12'd1);
      ins1 = enc_i(5'd9, 5'd0, 12'd2);
      drive(1'b1, ins0, 32'h200, 1'b0);
      tick();
      drive(1'b1, ins1, 32'h204, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_total++; if (o_ready !== 1'b0) $display("FAIL bp_ready c%0d: got %b want 0", c, o_ready); else n_pass++;
         tick();
         n_total++; if ({o_valid, o_pc, o_instr, o_rd_addr} !== {1'b1, 32'h200, ins0, 5'd8})
            $display("FAIL bp_hold c%0d: got v=%b pc=%h ins=%h rd=%0d want 1/200/%h/8", c, o_valid, o_pc, o_instr, o_rd_addr, ins0); else n_pass++;
      end
      ex_ready = 1'b1;
      #1;
      n_total++; if (o_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", o_ready); else n_pass++;
      tick();
      n_total++; if ({o_valid, o_pc, o_rd_addr} !== {1'b1, 32'h204, 5'd9})
         $display("FAIL bp_next: got v=%b pc=%h rd=%0d want 1/204/9", o_valid, o_pc, o_rd_addr); else n_pass++;
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
   endtask

   task automatic test_flush();
      drive(1'b1, enc_i(5'd7, 5'd0, 12'd3), 32'h300, 1'b0);
      tick();
      n_total++; if ({o_valid, dut.busy[7]} !== 2'b11) $display("FAIL flush_pre: got v=%b busy7=%b want 1/1", o_valid, dut.busy[7]); else n_pass++;
      drive(1'b1, enc_i(5'd10, 5'd0, 12'd4), 32'h304, 1'b0);
      flush = 1'b1;
      #1;
      n_total++; if (o_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", o_ready); else n_pass++;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_total++; if ({o_valid, dut.busy[7], dut.busy[10]} !== 3'b000)
         $display("FAIL flush_post: got v=%b busy7=%b busy10=%b want 0/0/0", o_valid, dut.busy[7], dut.busy[10]); else n_pass++;
   endtask

   task automatic test_store_x0();
      logic [31:0] busy_before;
      rf[2] = 32'hCAFE0000;
      busy_before = f_busy_vec();
      drive(1'b1, enc_s(5'd2, 5'd0, 12'd4), 32'h400, 1'b1);
      #1;
      n_total++; if (o_ready !== 1'b1) $display("FAIL store_ready: got %b want 1", o_ready); else n_pass++;
      tick();
      n_total++; if ({o_valid, o_rs1_val, o_rs2_val, o_rd_addr} !== {1'b1, 32'hCAFE0000, 32'd0, 5'd0})
         $display("FAIL store_out: got v=%b rs1=%h rs2=%h rd=%0d want 1/cafe0000/0/0", o_valid, o_rs1_val, o_rs2_val, o_rd_addr); else n_pass++;
      n_total++; if (dut.busy !== busy_before) $display("FAIL store_busy: got %h want %h", dut.busy, busy_before); else n_pass++;
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
   endtask

   task automatic test_random();
      logic [31:0] ins;
      int          q[$];
      for (int c = 0; c < 400; c++) begin
         ins = $urandom;
         case ($urandom_range(4))
            0:       ins[6:0] = 7'h13;
            1:       ins[6:0] = 7'h33;
            2:       ins[6:0] = 7'h23;
            3:       ins[6:0] = 7'h63;
            default: ins[6:0] = 7'h37;
         endcase
         ins[11:7]  = 5'($urandom_range(7));
         ins[19:15] = 5'($urandom_range(7));
         ins[24:20] = 5'($urandom_range(7));
         drive(1'($urandom_range(3) != 0), ins, $urandom, 1'($urandom_range(3) != 0));
         q.delete();
         for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
         if ($urandom_range(1) == 1) begin
            wb_we = 1'b1; wb_data = $urandom;
            wb_addr = (q.size() > 0 && $urandom_range(3) != 0) ? 5'(q[$urandom_range(q.size() - 1)]) : 5'($urandom_range(7));
         end
         flush = ($urandom_range(15) == 0);
         #1;
         n_total++; if (o_ready !== f_ready()) $display("FAIL rnd_ready c%0d: got %b want %b", c, o_ready, f_ready()); else n_pass++;
         tick();
         n_total++; if ({o_valid, o_pc, o_instr, o_rs1_val, o_rs2_val, o_rd_addr} !== {m_valid, m_pc, m_instr, m_rs1, m_rs2, m_rd})
            $display("FAIL rnd_out c%0d: got v=%b pc=%h ins=%h a=%h b=%h rd=%0d want v=%b pc=%h ins=%h a=%h b=%h rd=%0d", c,
                     o_valid, o_pc, o_instr, o_rs1_val, o_rs2_val, o_rd_addr, m_valid, m_pc, m_instr, m_rs1, m_rs2, m_rd); else n_pass++;
         n_total++; if (dut.busy !== f_busy_vec()) $display("FAIL rnd_busy c%0d: got %h want %h", c, dut.busy, f_busy_vec()); else n_pass++;
      end
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, enc_i(5'd12, 5'd0, 12'd5), 32'h500, 1'b0);
      tick();
      n_total++; if ({o_valid, dut.busy[12]} !== 2'b11) $display("FAIL rstmid_pre: got v=%b busy12=%b want 1/1", o_valid, dut.busy[12]); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++; if ({o_valid, o_pc, o_instr, o_rs1_val, o_rs2_val, o_rd_addr} !== 134'd0)
         $display("FAIL rstmid_outputs: got v=%b pc=%h rd=%0d want all zero", o_valid, o_pc, o_rd_addr); else n_pass++;
      n_total++; if (dut.busy !== 32'd0) $display("FAIL rstmid_busy: got %h want 0", dut.busy); else n_pass++;
      model_reset();
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_passthrough();
      test_raw();
      test_back_to_back();
      test_flush();
      test_store_x0();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
